// File: rtl/led_bar_pkg.sv
// Shared encodings and the index-to-pattern decoder for the LED bar sequencer.
package led_bar_pkg;

    localparam logic [1:0] MODE_BAR      = 2'd0;
    localparam logic [1:0] MODE_DOT      = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_RBAR     = 2'd3;

    localparam logic [1:0] RPT_IDLE   = 2'd0;
    localparam logic [1:0] RPT_DELAY  = 2'd1;
    localparam logic [1:0] RPT_REPEAT = 2'd2;

    localparam int MAX_LEDS = 32;

    function automatic logic [MAX_LEDS-1:0] pattern_decode(
        input logic [4:0] idx,
        input logic [1:0] mode,
        input int         n
    );
        logic [MAX_LEDS-1:0] pat;
        int                  k;
        k   = int'(idx);
        pat = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            case (mode)
                MODE_BAR:  pat[i] = (i <= k);
                MODE_RBAR: pat[i] = (i < n) && (i >= n - 1 - k);
                default:   pat[i] = (i == k);
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/btn_event.sv
// Press edge detector and hold-to-repeat FSM for one debounced button.
module btn_event
    import led_bar_pkg::*;
#(
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_RATE    = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_other_pressed,
    output logic o_pressed,
    output logic o_press,
    output logic o_tick
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
    localparam logic          REL_LEVEL  = (BTN_ACTIVE_LOW != 0);

    logic          r_btn_q;
    logic          r_lock;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;

    logic w_pressed;
    logic w_prev_pressed;
    logic w_press;
    logic w_hold;
    logic w_tick;

    assign w_pressed      = (i_btn != REL_LEVEL);
    assign w_prev_pressed = (r_btn_q != REL_LEVEL);
    // r_lock masks a button that was already down while reset was applied
    assign w_press        = w_pressed & ~w_prev_pressed & ~r_lock;
    assign w_hold         = w_pressed & ~i_other_pressed;

    assign w_tick = w_hold &
                    (((r_state == RPT_DELAY)  && (r_timer == DELAY_LAST)) ||
                     ((r_state == RPT_REPEAT) && (r_timer == RATE_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= REL_LEVEL;
            r_lock  <= w_pressed;
            r_state <= RPT_IDLE;
            r_timer <= '0;
        end else begin
            r_btn_q <= i_btn;
            if (!w_pressed) begin
                r_lock <= 1'b0;
            end
            case (r_state)
                RPT_IDLE: begin
                    if (w_press && !i_other_pressed) begin
                        r_state <= RPT_DELAY;
                        r_timer <= '0;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (!w_hold) begin
                        r_state <= RPT_IDLE;
                        r_timer <= '0;
                    end else if (w_tick) begin
                        r_state <= RPT_REPEAT;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= RPT_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign o_pressed = w_pressed;
    assign o_press   = w_press;
    assign o_tick    = w_tick;

endmodule

// File: rtl/led_bar_seq.sv
// LED bar sequencer: steps an index from buttons/auto-advance and drives
// one of four registered display patterns.
module led_bar_seq
    import led_bar_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_RATE    = 10_000_000,
    parameter int AUTO_PERIOD    = 25_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_next,
    input  logic                        btn_prev,
    input  logic [1:0]                  mode_sel,
    input  logic                        auto_en,
    output logic [NUM_LEDS-1:0]         led_out,
    output logic [$clog2(NUM_LEDS)-1:0] step_idx,
    output logic                        wrap_pulse
);

    localparam int IW    = $clog2(NUM_LEDS);
    localparam int TMAX2 = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMAX  = (TMAX2 > AUTO_PERIOD) ? TMAX2 : AUTO_PERIOD;
    localparam int ATW   = $clog2(TMAX + 1);

    localparam logic [IW-1:0]  LAST      = IW'(NUM_LEDS - 1);
    localparam logic [ATW-1:0] AUTO_LAST = ATW'(AUTO_PERIOD - 1);

    logic [IW-1:0]       r_idx;
    logic                r_down;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_wrap;
    logic [ATW-1:0]      r_auto_cnt;

    logic w_n_pressed;
    logic w_n_press;
    logic w_n_tick;
    logic w_p_pressed;
    logic w_p_press;
    logic w_p_tick;

    logic w_auto_tick;
    logic w_btn_evt;
    logic w_auto_clr;
    logic w_next_evt;
    logic w_prev_evt;
    logic w_pp;
    logic w_up;
    logic w_at_end;

    logic [IW-1:0]       w_nidx;
    logic                w_ndown;
    logic                w_npulse;
    logic [MAX_LEDS-1:0] w_pat;

    btn_event #(
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_next (
        .clk             (clk),
        .rst             (rst),
        .i_btn           (btn_next),
        .i_other_pressed (w_p_pressed),
        .o_pressed       (w_n_pressed),
        .o_press         (w_n_press),
        .o_tick          (w_n_tick)
    );

    btn_event #(
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_prev (
        .clk             (clk),
        .rst             (rst),
        .i_btn           (btn_prev),
        .i_other_pressed (w_n_pressed),
        .o_pressed       (w_p_pressed),
        .o_press         (w_p_press),
        .o_tick          (w_p_tick)
    );

    assign w_auto_tick = auto_en && (r_auto_cnt == AUTO_LAST);
    assign w_btn_evt   = w_n_press | w_n_tick | w_p_press | w_p_tick;
    assign w_auto_clr  = !auto_en || w_auto_tick || w_btn_evt;

    assign w_next_evt = w_n_press | w_n_tick | w_auto_tick;
    assign w_prev_evt = w_p_press | w_p_tick;

    // In ping-pong, "next" follows dir and "prev" runs against it
    assign w_pp     = (mode_sel == MODE_PINGPONG);
    assign w_up     = w_pp ? (w_next_evt ^ r_down) : w_next_evt;
    assign w_at_end = w_up ? (r_idx == LAST) : (r_idx == '0);

    always_comb begin
        w_nidx   = r_idx;
        w_ndown  = w_pp & r_down;
        w_npulse = 1'b0;
        if (w_next_evt != w_prev_evt) begin
            if (!w_at_end) begin
                w_nidx = w_up ? r_idx + IW'(1) : r_idx - IW'(1);
            end else if (!w_pp) begin
                w_nidx   = w_up ? '0 : LAST;
                w_npulse = 1'b1;
            end else if (w_next_evt) begin
                w_nidx   = w_up ? LAST - IW'(1) : IW'(1);
                w_ndown  = w_up;
                w_npulse = 1'b1;
            end
        end
    end

    assign w_pat = pattern_decode(5'(w_nidx), mode_sel, NUM_LEDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_down     <= 1'b0;
            r_led      <= NUM_LEDS'(1);
            r_wrap     <= 1'b0;
            r_auto_cnt <= '0;
        end else begin
            r_idx      <= w_nidx;
            r_down     <= w_ndown;
            r_led      <= w_pat[NUM_LEDS-1:0];
            r_wrap     <= w_npulse;
            r_auto_cnt <= w_auto_clr ? '0 : r_auto_cnt + ATW'(1);
        end
    end

    assign led_out    = r_led;
    assign step_idx   = r_idx;
    assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_led_bar_seq.sv
// Scoreboard bench for led_bar_seq (N=5, delay 10, rate 3, auto period 8).
module tb_led_bar_seq;

    typedef struct {
        int         cyc;
        int         idx;
        logic [4:0] led;
        logic       pulse;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_prev;
    logic [1:0] mode_sel;
    logic       auto_en;
    logic [4:0] led_out;
    logic [2:0] step_idx;
    logic       wrap_pulse;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    exp_t q[$];
    exp_t e;
    logic [2:0] p_idx;
    logic [4:0] p_led;

    led_bar_seq #(
        .NUM_LEDS       (5),
        .BTN_ACTIVE_LOW (1),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .AUTO_PERIOD    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .mode_sel   (mode_sel),
        .auto_en    (auto_en),
        .led_out    (led_out),
        .step_idx   (step_idx),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) cyc_wait(1);
    endtask

    task automatic expect_ev(input int c, input int idx, input logic [4:0] led, input logic p);
        exp_t x;
        x.cyc   = c;
        x.idx   = idx;
        x.led   = led;
        x.pulse = p;
        q.push_back(x);
    endtask

    task automatic press(input bit nx, input bit pv);
        if (nx) btn_next = 1'b0;
        if (pv) btn_prev = 1'b0;
        cyc_wait(1);
        btn_next = 1'b1;
        btn_prev = 1'b1;
        cyc_wait(2);
    endtask

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic check_drained(input string nm);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events pending, required 0", nm, q.size());
            q.delete();
        end
    endtask

    // Monitor: any visible output change is an event and must match the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event: none at cycle %0d, required idx=%0d led=%b",
                         q[0].cyc, q[0].idx, q[0].led);
                q.delete(0);
            end
            if (step_idx != p_idx || led_out != p_led || wrap_pulse) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cyc=%0d idx=%0d led=%b pulse=%b, required no change",
                             cyc, step_idx, led_out, wrap_pulse);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || int'(step_idx) != e.idx ||
                        led_out !== e.led || wrap_pulse !== e.pulse) begin
                        n_fail++;
                        $display("FAIL event: cyc=%0d idx=%0d led=%b pulse=%b, required cyc=%0d idx=%0d led=%b pulse=%b",
                                 cyc, step_idx, led_out, wrap_pulse, e.cyc, e.idx, e.led, e.pulse);
                    end
                end
            end
            p_idx = step_idx;
            p_led = led_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a_idx[5];
        logic [4:0] a_led[5];
        int         c0;
        a_idx = '{1, 2, 3, 4, 0};
        a_led = '{5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00001};

        rst      = 1'b1;
        btn_next = 1'b1;
        btn_prev = 1'b1;
        mode_sel = 2'd0;
        auto_en  = 1'b0;
        cyc_wait(3);
        rst = 1'b0;
        check("reset_idx", int'(step_idx), 0);
        check("reset_led", int'(led_out), 1);
        check("reset_wrap", int'(wrap_pulse), 0);
        p_idx  = step_idx;
        p_led  = led_out;
        mon_en = 1'b1;

        // BAR: five next presses, wrap on the fifth
        for (int i = 0; i < 5; i++) begin
            expect_ev(cyc + 1, a_idx[i], a_led[i], (i == 4));
            press(1'b1, 1'b0);
        end

        // DOT: prev wraps 0 -> 4, simultaneous presses cancel
        mode_sel = 2'd1;
        cyc_wait(1);
        expect_ev(cyc + 1, 4, 5'b10000, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        cyc_wait(3);
        check_drained("cancel");
        expect_ev(cyc + 1, 0, 5'b00001, 1'b1);
        press(1'b1, 1'b0);

        // PINGPONG: hold next, first step at press, +10, then every 3
        mode_sel = 2'd2;
        cyc_wait(1);
        c0 = cyc + 1;
        expect_ev(c0,      1, 5'b00010, 1'b0);
        expect_ev(c0 + 10, 2, 5'b00100, 1'b0);
        expect_ev(c0 + 13, 3, 5'b01000, 1'b0);
        expect_ev(c0 + 16, 4, 5'b10000, 1'b0);
        expect_ev(c0 + 19, 3, 5'b01000, 1'b1);
        expect_ev(c0 + 22, 2, 5'b00100, 1'b0);
        expect_ev(c0 + 25, 1, 5'b00010, 1'b0);
        expect_ev(c0 + 28, 0, 5'b00001, 1'b0);
        expect_ev(c0 + 31, 1, 5'b00010, 1'b1);
        btn_next = 1'b0;
        cyc_wait(32);
        btn_next = 1'b1;
        cyc_wait(4);
        check_drained("repeat_hold");
        expect_ev(cyc + 1, 0, 5'b00001, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        cyc_wait(2);
        check_drained("pp_saturate");
        expect_ev(cyc + 1, 1, 5'b00010, 1'b0);
        press(1'b1, 1'b0);

        // RBAR with auto-advance every 8, press mid-count restarts spacing
        mode_sel = 2'd3;
        expect_ev(cyc + 1, 1, 5'b11000, 1'b0);
        cyc_wait(2);
        c0 = cyc;
        auto_en = 1'b1;
        expect_ev(c0 + 8,  2, 5'b11100, 1'b0);
        expect_ev(c0 + 16, 3, 5'b11110, 1'b0);
        expect_ev(c0 + 24, 4, 5'b11111, 1'b0);
        expect_ev(c0 + 32, 0, 5'b10000, 1'b1);
        expect_ev(c0 + 40, 1, 5'b11000, 1'b0);
        expect_ev(c0 + 43, 2, 5'b11100, 1'b0);
        expect_ev(c0 + 51, 3, 5'b11110, 1'b0);
        wait_until(c0 + 42);
        btn_next = 1'b0;
        cyc_wait(1);
        btn_next = 1'b1;
        wait_until(c0 + 52);
        auto_en = 1'b0;
        cyc_wait(10);
        check_drained("auto");

        // Reset during REPEAT at idx 3 aborts; held button gives no step
        mode_sel = 2'd0;
        expect_ev(cyc + 1, 3, 5'b01111, 1'b0);
        cyc_wait(2);
        expect_ev(cyc + 1, 4, 5'b11111, 1'b0);
        press(1'b1, 1'b0);
        expect_ev(cyc + 1, 0, 5'b00001, 1'b1);
        press(1'b1, 1'b0);
        c0 = cyc + 1;
        expect_ev(c0,      1, 5'b00011, 1'b0);
        expect_ev(c0 + 10, 2, 5'b00111, 1'b0);
        expect_ev(c0 + 13, 3, 5'b01111, 1'b0);
        btn_next = 1'b0;
        cyc_wait(14);
        rst = 1'b1;
        expect_ev(c0 + 14, 0, 5'b00001, 1'b0);
        cyc_wait(1);
        rst = 1'b0;
        cyc_wait(20);
        btn_next = 1'b1;
        cyc_wait(2);
        check_drained("rst_abort");
        expect_ev(cyc + 1, 1, 5'b00011, 1'b0);
        press(1'b1, 1'b0);

        // Mode switch BAR -> DOT at idx 2 changes only the pattern
        expect_ev(cyc + 1, 2, 5'b00111, 1'b0);
        press(1'b1, 1'b0);
        mode_sel = 2'd1;
        expect_ev(cyc + 1, 2, 5'b00100, 1'b0);
        cyc_wait(3);
        check("mode_switch_idx", int'(step_idx), 2);
        check_drained("final");

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
